mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter for the single memory port (`Memoria`) of the multicycle CPU. It shares that port between two requesters: the CPU fetch/load/store path (port 0) and an auxiliary loader/debug master (port 1). Arbitration is round-robin. Each requester sees a req/ack handshake; the block drives the memory address, write strobe and write data, and waits out the memory read latency.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `READ_LAT`, default 1: memory read latency in cycles, from the address cycle to valid `mem_dout`; legal range 1..8.
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: requester asks for a transaction; hold high until its ack.
- `wr0`, `wr1` in 1: 1 = write, 0 = read; stable while req high.
- `addr0`, `addr1` in ADDR_W: transaction address; stable while req high.
- `wdata0`, `wdata1` in DATA_W: write data; stable while req high.
- `ack0`, `ack1` out 1: one-cycle completion pulse to the owning requester.
- `rdata` out DATA_W: read data, valid in the ack cycle; held until the next read capture.
- `gnt` out 2: one-hot owner of the port; 00 when idle.
- `busy` out 1: high in every state except IDLE.
- `mem_addr` out ADDR_W: memory address.
- `mem_wr` out 1: memory write strobe.
- `mem_din` out DATA_W: memory write data.
- `mem_dout` in DATA_W: memory read data.

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- **IDLE:** if any req is high, pick the winner and go to ACCESS. On that edge, latch the winner's addr/wr/wdata into `mem_addr`, a write flag and `mem_din`, and set `gnt`.
- **Winner selection:** if only one req is high, it wins. If both are high, the port not served last wins (`last_gnt` flips on every grant). `last_gnt` resets to 1, so port 0 wins the first tie.
- **ACCESS (one cycle):** `mem_wr` = latched write flag.
  - Write: go to DONE.
  - Read with READ_LAT=1: capture `mem_dout` into `rdata` at the end of ACCESS, then go to DONE.
  - Read with READ_LAT>1: load a down-counter with READ_LAT-1, then go to WAIT.
- **WAIT:** decrement the counter. When it reaches 0, capture `mem_dout` into `rdata` and go to DONE.
- **DONE (one cycle):** pulse the owner's ack, clear `gnt`, go to IDLE.
- `mem_wr` is high only in ACCESS for writes, never in any other state.
- `mem_addr` and `mem_din` hold their latched values through DONE and IDLE until the next grant.
- If a requester drops req before its ack, the latched transaction still completes and still acks. This is a protocol violation, but the behaviour is defined.
- A requester may hold req high through its ack cycle to issue a new transaction. It is sampled again in the following IDLE and competes under round-robin.
- Async reset (`reset` = 0):
  - Immediately: state = IDLE, `gnt` = 00, `ack0`/`ack1` = 0, `mem_wr` = 0, `busy` = 0.
  - Registers: `mem_addr`, `mem_din`, `rdata` and the counter go to 0; `last_gnt` goes to 1.
  - A transaction in flight is dropped with no ack.

## Timing
- Requests are sampled in IDLE at cycle T.
- Write: `mem_wr` high at T+1; ack at T+2.
- Read: ack at T+1+READ_LAT; `rdata` valid in that cycle.
- Minimum spacing between grants is 3 cycles for writes and READ_LAT+2 cycles for reads, because DONE and IDLE each take one cycle.
- No combinational path from any req/addr input to any output; all outputs are registered.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic [1:0]` for the state: IDLE, ACCESS, WAIT, DONE.
  - Constants `PORT_CPU = 0`, `PORT_AUX = 1`.
- No sub-module. Winner selection is a few lines inside the block.
- The counter is 3 bits, wide enough for READ_LAT up to 8.

## Test plan
- **Single read, port 0, READ_LAT=1:** `addr0`=0x10, memory holds 0xDEADBEEF there. Required: `gnt`=01 at T+1, `ack0` at T+2 with `rdata`=0xDEADBEEF, `mem_wr` never high.
- **Single write, port 1:** `addr1`=0x20, `wdata1`=0x12345678. Required: `mem_wr`=1 with `mem_addr`=0x20 and `mem_din`=0x12345678 only at T+1, `ack1` at T+2. A following read of 0x20 returns 0x12345678.
- **Simultaneous req0/req1 held for 4 transactions:** Required grant order 0,1,0,1. Each ack lands only on its owner; `ack0` and `ack1` are never high together.
- **READ_LAT=3, read on port 0:** Required: ack at T+4; `busy` high for T+1..T+4; `rdata` taken from `mem_dout` at the end of the last WAIT cycle.
- **Reset low during WAIT:** Required: immediately `busy`=0, `gnt`=00, `mem_wr`=0, no ack. After release, the first tie is granted to port 0.
- **req0 dropped in ACCESS:** Required: `ack0` is still pulsed at the normal cycle, then the block returns to IDLE with `gnt`=00.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
// State encoding and requester port numbers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the single memory port.
// Serves CPU (port 0) and aux loader (port 1).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    arb_state_t        r_state;
    logic              r_own;
    logic              r_last;
    logic              r_wr;
    logic [1:0]        r_gnt;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_rdata;
    logic              w_win;

    // Winner: a lone requester, else whoever was not served last.
    always_comb begin
        w_win = PORT_CPU;
        if (req0 && req1) begin
            w_win = ~r_last;
        end else if (req1) begin
            w_win = PORT_AUX;
        end
    end

    // Transaction sequencing: grant, access, read wait, completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_own   <= PORT_CPU;
            r_last  <= PORT_AUX;
            r_wr    <= 1'b0;
            r_gnt   <= 2'b00;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_din   <= '0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req0 || req1) begin
                        r_state <= ACCESS;
                        r_own   <= w_win;
                        r_last  <= w_win;
                        r_gnt   <= (w_win == PORT_AUX) ? 2'b10 : 2'b01;
                        r_wr    <= (w_win == PORT_AUX) ? wr1 : wr0;
                        r_addr  <= (w_win == PORT_AUX) ? addr1 : addr0;
                        r_din   <= (w_win == PORT_AUX) ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    if (r_wr) begin
                        r_state <= DONE;
                    end else if (READ_LAT == 1) begin
                        r_rdata <= mem_dout;
                        r_state <= DONE;
                    end else begin
                        r_cnt   <= LAT_M1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_rdata <= mem_dout;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_gnt   <= 2'b00;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign mem_wr   = (r_state == ACCESS) && r_wr;
    assign ack0     = (r_state == DONE) && (r_own == PORT_CPU);
    assign ack1     = (r_state == DONE) && (r_own == PORT_AUX);
    assign gnt      = r_gnt;
    assign mem_addr = r_addr;
    assign mem_din  = r_din;
    assign rdata    = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: READ_LAT=1 and READ_LAT=3 instances,
// transaction-level timing model plus directed literal checks.
module tb_mem_port_arbiter;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          drop;
    } txn_t;

    logic        clock;
    logic        rst     [2];
    logic        req_i   [2][2];
    logic        wr_i    [2][2];
    logic [31:0] addr_i  [2][2];
    logic [31:0] wd_i    [2][2];
    logic        ack_o   [2][2];
    logic [31:0] rdata_o [2];
    logic [1:0]  gnt_o   [2];
    logic        busy_o  [2];
    logic [31:0] maddr_o [2];
    logic        mwr_o   [2];
    logic [31:0] mdin_o  [2];
    logic [31:0] mdout_i [2];

    txn_t        q [4][$];
    int          pend [2];
    int          n_chk;
    int          n_pass;

    int          g_cyc [2];
    int          a_cyc [2];
    int          a_port [2];
    int          nack [2];
    int          nwr [2];
    int          busyc [2];
    logic [31:0] a_rd [2];
    logic [31:0] w_addr [2];
    logic [31:0] w_din [2];
    int          gord [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, got, exp);
    endtask

    task automatic push(input int g, input int p, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit drop);
        txn_t t;
        t.wr = wr;
        t.addr = a;
        t.data = d;
        t.drop = drop;
        q[g*2+p].push_back(t);
        pend[g]++;
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (pend[g] != 0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        if (pend[g] != 0) begin
            n_chk++;
            $display("FAIL idle_timeout inst %0d: pending %0d required 0",
                     g, pend[g]);
        end
        repeat (3) @(posedge clock);
        #2;
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int LAT = (g == 0) ? 1 : 3;
        localparam int PI  = (LAT > 1) ? LAT - 2 : 0;

        logic [31:0] mem  [256];
        logic [31:0] pipe [8];
        logic [31:0] mref [256];

        bit          m_act;
        bit          m_last;
        bit          m_wr;
        bit          m_own;
        int          k;
        int          dur;
        int          cyc;
        logic [31:0] m_addr;
        logic [31:0] m_din;
        logic [31:0] m_rd;
        logic [1:0]  prev_gnt;

        mem_port_arbiter #(
            .ADDR_W  (32),
            .DATA_W  (32),
            .READ_LAT(LAT)
        ) u_dut (
            .clock   (clock),
            .reset   (rst[g]),
            .req0    (req_i[g][0]),
            .req1    (req_i[g][1]),
            .wr0     (wr_i[g][0]),
            .wr1     (wr_i[g][1]),
            .addr0   (addr_i[g][0]),
            .addr1   (addr_i[g][1]),
            .wdata0  (wd_i[g][0]),
            .wdata1  (wd_i[g][1]),
            .ack0    (ack_o[g][0]),
            .ack1    (ack_o[g][1]),
            .rdata   (rdata_o[g]),
            .gnt     (gnt_o[g]),
            .busy    (busy_o[g]),
            .mem_addr(maddr_o[g]),
            .mem_wr  (mwr_o[g]),
            .mem_din (mdin_o[g]),
            .mem_dout(mdout_i[g])
        );

        initial begin
            for (int i = 0; i < 256; i++) begin
                mem[i]  = 32'h5500_0000 ^ 32'(i);
                mref[i] = 32'h5500_0000 ^ 32'(i);
            end
            mem[0]     = 32'h0BAD_F00D;
            mref[0]    = 32'h0BAD_F00D;
            mem[8'h10] = 32'hDEAD_BEEF;
            mref[8'h10] = 32'hDEAD_BEEF;
            mem[8'h30] = 32'hCAFE_F00D;
            mref[8'h30] = 32'hCAFE_F00D;
            m_act = 0;
            m_last = 1;
            k = 0;
            dur = 0;
            cyc = 0;
            m_addr = 0;
            m_din = 0;
            m_rd = 0;
            prev_gnt = 2'b00;
        end

        // Memory: writes on the edge; reads delayed LAT-1 registers.
        always @(posedge clock) begin
            if (mwr_o[g]) mem[maddr_o[g][7:0]] <= mdin_o[g];
            pipe[0] <= mem[maddr_o[g][7:0]];
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        end
        assign mdout_i[g] = (LAT == 1) ? mem[maddr_o[g][7:0]] : pipe[PI];

        // Requester agents: hold req until ack, chain queued txns.
        initial begin : agent
            txn_t cur [2];
            bit   act [2];
            bit   got [2];
            int   age [2];
            for (int p = 0; p < 2; p++) begin
                req_i[g][p] = 0;
                wr_i[g][p] = 0;
                addr_i[g][p] = 0;
                wd_i[g][p] = 0;
                act[p] = 0;
                got[p] = 0;
                age[p] = 0;
            end
            forever begin
                @(posedge clock);
                #1;
                for (int p = 0; p < 2; p++) begin
                    if (act[p]) begin
                        if (got[p]) begin
                            act[p] = 0;
                            pend[g]--;
                        end else begin
                            age[p]++;
                            if (cur[p].drop && age[p] == 1) req_i[g][p] = 0;
                            if (ack_o[g][p]) begin
                                got[p] = 1;
                            end else if (age[p] > 60) begin
                                n_chk++;
                                $display("FAIL ack_timeout inst %0d port %0d: %0d cycles, required ack",
                                         g, p, age[p]);
                                act[p] = 0;
                                req_i[g][p] = 0;
                                pend[g]--;
                            end
                        end
                    end
                    if (!act[p]) begin
                        if (q[g*2+p].size() > 0) begin
                            cur[p] = q[g*2+p].pop_front();
                            req_i[g][p] = 1;
                            wr_i[g][p] = cur[p].wr;
                            addr_i[g][p] = cur[p].addr;
                            wd_i[g][p] = cur[p].data;
                            act[p] = 1;
                            got[p] = 0;
                            age[p] = 0;
                        end else begin
                            req_i[g][p] = 0;
                        end
                    end
                end
            end
        end

        // Model: outputs as a function of cycles since grant.
        always @(negedge clock) begin
            logic [1:0] eg;
            cyc++;
            if (!rst[g]) begin
                chk($sformatf("rst_busy[%0d]", g), busy_o[g], 0);
                chk($sformatf("rst_gnt[%0d]", g), gnt_o[g], 0);
                chk($sformatf("rst_wr[%0d]", g), mwr_o[g], 0);
                chk($sformatf("rst_ack0[%0d]", g), ack_o[g][0], 0);
                chk($sformatf("rst_ack1[%0d]", g), ack_o[g][1], 0);
                chk($sformatf("rst_addr[%0d]", g), maddr_o[g], 0);
                chk($sformatf("rst_rdata[%0d]", g), rdata_o[g], 0);
                m_act = 0;
                m_last = 1;
                m_addr = 0;
                m_din = 0;
                m_rd = 0;
            end else begin
                if (m_act && !m_wr && k == dur) m_rd = mref[m_addr[7:0]];
                chk($sformatf("busy[%0d]", g), busy_o[g], m_act);
                chk($sformatf("mem_wr[%0d]", g), mwr_o[g],
                    m_act && m_wr && k == 1);
                chk($sformatf("ack0[%0d]", g), ack_o[g][0],
                    m_act && k == dur && m_own == 0);
                chk($sformatf("ack1[%0d]", g), ack_o[g][1],
                    m_act && k == dur && m_own == 1);
                chk($sformatf("mem_addr[%0d]", g), maddr_o[g], m_addr);
                chk($sformatf("mem_din[%0d]", g), mdin_o[g], m_din);
                chk($sformatf("rdata[%0d]", g), rdata_o[g], m_rd);
                if (!m_act || k < dur) begin
                    eg = !m_act ? 2'b00 : (m_own ? 2'b10 : 2'b01);
                    chk($sformatf("gnt[%0d]", g), gnt_o[g], eg);
                end
                if (m_act) begin
                    if (k == dur) begin
                        m_act = 0;
                        if (m_wr) mref[m_addr[7:0]] = m_din;
                    end else begin
                        k++;
                    end
                end else if (req_i[g][0] || req_i[g][1]) begin
                    if (req_i[g][0] && req_i[g][1]) m_own = (m_last == 1) ? 0 : 1;
                    else m_own = req_i[g][1];
                    m_last = m_own;
                    m_wr = wr_i[g][m_own];
                    m_addr = addr_i[g][m_own];
                    m_din = wd_i[g][m_own];
                    m_act = 1;
                    k = 1;
                    dur = m_wr ? 2 : LAT + 1;
                end
            end
            if (gnt_o[g] != 0 && prev_gnt == 0) begin
                gord.push_back(g * 16 + (gnt_o[g][1] ? 1 : 0));
                g_cyc[g] = cyc;
            end
            if (ack_o[g][0] || ack_o[g][1]) begin
                a_cyc[g] = cyc;
                a_port[g] = ack_o[g][1] ? 1 : 0;
                a_rd[g] = rdata_o[g];
                nack[g]++;
            end
            if (mwr_o[g]) begin
                nwr[g]++;
                w_addr[g] = maddr_o[g];
                w_din[g] = mdin_o[g];
            end
            if (busy_o[g]) busyc[g]++;
            prev_gnt = gnt_o[g];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sv;
        n_chk = 0;
        n_pass = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0;
            nack[i] = 0;
            nwr[i] = 0;
            busyc[i] = 0;
            g_cyc[i] = 0;
            a_cyc[i] = 0;
            a_port[i] = 0;
        end
        rst[0] = 0;
        rst[1] = 0;
        repeat (3) @(posedge clock);
        #2;
        rst[0] = 1;
        rst[1] = 1;
        chk("lit_rst_busy", busy_o[0], 0);
        chk("lit_rst_gnt", gnt_o[0], 2'b00);
        chk("lit_rst_rdata", rdata_o[0], 0);

        push(0, 0, 0, 32'h10, 0, 0);
        wait_idle(0);
        chk("lit_rd_lat", a_cyc[0] - g_cyc[0], 1);
        chk("lit_rd_port", a_port[0], 0);
        chk("lit_rd_data", a_rd[0], 32'hDEAD_BEEF);
        chk("lit_rd_nowr", nwr[0], 0);

        push(0, 1, 1, 32'h20, 32'h1234_5678, 0);
        wait_idle(0);
        chk("lit_wr_cnt", nwr[0], 1);
        chk("lit_wr_addr", w_addr[0], 32'h20);
        chk("lit_wr_din", w_din[0], 32'h1234_5678);
        chk("lit_wr_port", a_port[0], 1);
        chk("lit_wr_lat", a_cyc[0] - g_cyc[0], 1);

        gord.delete();
        sv = nack[0];
        push(0, 0, 0, 32'h10, 0, 0);
        push(0, 0, 1, 32'h40, 32'hA5A5_A5A5, 0);
        push(0, 1, 1, 32'h44, 32'h5A5A_5A5A, 0);
        push(0, 1, 0, 32'h44, 0, 0);
        wait_idle(0);
        chk("lit_rr_n", gord.size(), 4);
        if (gord.size() == 4) begin
            chk("lit_rr_0", gord[0], 0);
            chk("lit_rr_1", gord[1], 1);
            chk("lit_rr_2", gord[2], 0);
            chk("lit_rr_3", gord[3], 1);
        end
        chk("lit_rr_acks", nack[0] - sv, 4);
        chk("lit_rr_rd", a_rd[0], 32'h5A5A_5A5A);

        push(0, 0, 0, 32'h20, 0, 0);
        wait_idle(0);
        chk("lit_rdback", a_rd[0], 32'h1234_5678);

        push(0, 0, 0, 32'h40, 0, 1);
        wait_idle(0);
        chk("lit_drop_port", a_port[0], 0);
        chk("lit_drop_lat", a_cyc[0] - g_cyc[0], 1);
        chk("lit_drop_data", a_rd[0], 32'hA5A5_A5A5);
        chk("lit_drop_gnt", gnt_o[0], 2'b00);

        busyc[1] = 0;
        push(1, 0, 0, 32'h30, 0, 0);
        wait_idle(1);
        chk("lit_l3_lat", a_cyc[1] - g_cyc[1], 3);
        chk("lit_l3_busy", busyc[1], 4);
        chk("lit_l3_data", a_rd[1], 32'hCAFE_F00D);

        push(1, 0, 0, 32'h10, 0, 0);
        n = 0;
        while (gnt_o[1] == 2'b00 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        @(posedge clock);
        #1;
        @(negedge clock);
        #2;
        sv = nack[1];
        rst[1] = 0;
        #1;
        chk("lit_arst_busy", busy_o[1], 0);
        chk("lit_arst_gnt", gnt_o[1], 2'b00);
        chk("lit_arst_wr", mwr_o[1], 0);
        chk("lit_arst_ack0", ack_o[1][0], 0);
        chk("lit_arst_ack1", ack_o[1][1], 0);
        gord.delete();
        push(1, 1, 0, 32'h30, 0, 0);
        repeat (2) @(posedge clock);
        #2;
        chk("lit_arst_noack", nack[1], sv);
        rst[1] = 1;
        wait_idle(1);
        chk("lit_tie_n", gord.size(), 2);
        if (gord.size() == 2) begin
            chk("lit_tie_0", gord[0], 16);
            chk("lit_tie_1", gord[1], 17);
        end
        chk("lit_tie_rd", a_rd[1], 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
